// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer tick scheduler: timer register map,
// control word encodings, FSM state type and the round-robin pointer helper.
package timer_sched_pkg;

   // Width of requester indices and of the active_id output
   localparam int ID_W = 3;

   // Interval-timer word addresses
   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;

   // Control register bit positions
   localparam int CTRL_ITO_BIT   = 0;
   localparam int CTRL_CONT_BIT  = 1;
   localparam int CTRL_START_BIT = 2;
   localparam int CTRL_STOP_BIT  = 3;

   // One-shot start with interrupt enabled, and a plain stop with the interrupt masked
   localparam logic [15:0] CTRL_START_ONESHOT = 16'h0005;
   localparam logic [15:0] CTRL_STOP          = 16'h0008;

   typedef enum logic [3:0] {
      IDLE,
      ARB,
      WR_PL,
      WR_PH,
      WR_CTRL,
      WAIT,
      STOP,
      CLR,
      DONE
   } sched_state_t;

   // Pointer to the requester after g, wrapping at n
   function automatic logic [ID_W-1:0] rr_next_ptr(input logic [ID_W-1:0] g, input int n);
      if (int'(g) >= n - 1) begin
         return '0;
      end
      return g + 1'b1;
   endfunction

endpackage

// File: rtl/timer_tick_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above the
// pointer, wrapping to the lowest active request when none is above it.
module rr_arbiter
   import timer_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_valid
);

   logic [NUM_REQ-1:0] hi_req;
   logic [NUM_REQ-1:0] pick_vec;

   // Requests at or above the pointer take priority over the wrapped ones
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
         assign hi_req[gi] = req[gi] & (ID_W'(gi) >= ptr);
      end
   endgenerate

   assign pick_vec    = (|hi_req) ? hi_req : req;
   assign grant_valid = |req;

   // Lowest set bit of the selected vector wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pick_vec[i]) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Shares one interval timer between NUM_REQ requesters: arbitrates,
// programs a one-shot delay, waits for irq (or abort), clears the timer
// status and pulses done to the owner.
module timer_tick_scheduler
   import timer_sched_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int PERIOD_W = 32
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*PERIOD_W-1:0]  req_period,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           done,
   output logic                         done_aborted,
   input  logic                         abort,
   output logic                         busy,
   output logic [ID_W-1:0]              active_id,
   output logic [2:0]                   tmr_address,
   output logic                         tmr_chipselect,
   output logic                         tmr_write_n,
   output logic [15:0]                  tmr_writedata,
   input  logic                         tmr_irq
);

   localparam logic [PERIOD_W-1:0] ONE_P = 1;

   sched_state_t     state_reg, state_next;
   logic [ID_W-1:0]  id_reg, id_next;
   logic [ID_W-1:0]  ptr_reg, ptr_next;
   logic [31:0]      period_m1_reg, period_m1_next;
   logic             aborted_reg, aborted_next;
   logic             abort_pend_reg, abort_pend_next;

   logic [PERIOD_W-1:0] period_arr [NUM_REQ];
   logic [PERIOD_W-1:0] sel_period;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic                grant_valid;
   logic                arb_en;

   // Unpack the flat period bus into one slice per requester
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_period
         assign period_arr[gi] = req_period[gi*PERIOD_W +: PERIOD_W];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ     (NUM_REQ)
   ) u_arb (
      .req         (req_valid),
      .ptr         (ptr_reg),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Period of the granted requester, selected by the one-hot grant
   always_comb begin
      sel_period = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_period = period_arr[i];
         end
      end
   end

   // State and transaction registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         id_reg         <= '0;
         ptr_reg        <= '0;
         period_m1_reg  <= '0;
         aborted_reg    <= 1'b0;
         abort_pend_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         id_reg         <= id_next;
         ptr_reg        <= ptr_next;
         period_m1_reg  <= period_m1_next;
         aborted_reg    <= aborted_next;
         abort_pend_reg <= abort_pend_next;
      end
   end

   // Next-state logic; abort seen during the register writes is held
   // until WAIT, and irq always beats abort in WAIT
   always_comb begin
      state_next      = state_reg;
      id_next         = id_reg;
      ptr_next        = ptr_reg;
      period_m1_next  = period_m1_reg;
      aborted_next    = aborted_reg;
      abort_pend_next = abort_pend_reg;
      arb_en          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|req_valid) begin
               state_next = ARB;
            end
         end
         ARB: begin
            arb_en = 1'b1;
            if (grant_valid) begin
               id_next        = grant_idx;
               ptr_next       = rr_next_ptr(grant_idx, NUM_REQ);
               period_m1_next = 32'(sel_period - ONE_P);
               state_next     = (sel_period == '0) ? DONE : WR_PL;
            end else begin
               // Request withdrawn before grant: nothing to serve
               state_next = IDLE;
            end
         end
         WR_PL: begin
            if (abort) abort_pend_next = 1'b1;
            state_next = WR_PH;
         end
         WR_PH: begin
            if (abort) abort_pend_next = 1'b1;
            state_next = WR_CTRL;
         end
         WR_CTRL: begin
            if (abort) abort_pend_next = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (tmr_irq) begin
               abort_pend_next = 1'b0;
               state_next      = CLR;
            end else if (abort || abort_pend_reg) begin
               abort_pend_next = 1'b0;
               state_next      = STOP;
            end
         end
         STOP: begin
            aborted_next = 1'b1;
            state_next   = CLR;
         end
         CLR: begin
            state_next = DONE;
         end
         DONE: begin
            aborted_next    = 1'b0;
            abort_pend_next = 1'b0;
            state_next      = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Timer master port: one single-cycle write per write state, idle otherwise
   always_comb begin
      tmr_chipselect = 1'b0;
      tmr_write_n    = 1'b1;
      tmr_address    = '0;
      tmr_writedata  = '0;
      case (state_reg)
         WR_PL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_PERIODL;
            tmr_writedata  = period_m1_reg[15:0];
         end
         WR_PH: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_PERIODH;
            tmr_writedata  = period_m1_reg[31:16];
         end
         WR_CTRL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_CONTROL;
            tmr_writedata  = CTRL_START_ONESHOT;
         end
         STOP: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_CONTROL;
            tmr_writedata  = CTRL_STOP;
         end
         CLR: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_STATUS;
            tmr_writedata  = 16'h0000;
         end
         default: begin
         end
      endcase
   end

   // Completion pulse to the owner only
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_done
         assign done[gi] = (state_reg == DONE) && (id_reg == ID_W'(gi));
      end
   endgenerate

   assign req_ready    = arb_en ? grant : '0;
   assign done_aborted = (state_reg == DONE) && aborted_reg;
   assign busy         = (state_reg != IDLE);
   assign active_id    = (arb_en && grant_valid) ? grant_idx : id_reg;

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler with a behavioural interval timer.
module tb_timer_tick_scheduler;

   localparam int NR = 4;
   localparam int PW = 32;

   logic              clk;
   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR*PW-1:0]  req_period;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     done;
   logic              done_aborted;
   logic              abort;
   logic              busy;
   logic [2:0]        active_id;
   logic [2:0]        tmr_address;
   logic              tmr_chipselect;
   logic              tmr_write_n;
   logic [15:0]       tmr_writedata;
   logic              tmr_irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_cyc = 0;
   int bad_strobe = 0;

   logic [18:0] wr_q[$];
   int          ev_q[$];

   timer_tick_scheduler #(
      .NUM_REQ        (NR),
      .PERIOD_W       (PW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_period     (req_period),
      .req_ready      (req_ready),
      .done           (done),
      .done_aborted   (done_aborted),
      .abort          (abort),
      .busy           (busy),
      .active_id      (active_id),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tmr_irq        (tmr_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural interval timer: one-shot countdown from the period value
   logic [15:0] t_pl, t_ph;
   logic [31:0] t_cnt;
   logic        t_run, t_to, t_ito, t_cont;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_pl <= '0; t_ph <= '0; t_cnt <= '0;
         t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
      end else begin
         if (t_run) begin
            if (t_cnt == 0) begin
               t_to  <= 1'b1;
               t_cnt <= {t_ph, t_pl};
               if (!t_cont) t_run <= 1'b0;
            end else begin
               t_cnt <= t_cnt - 1;
            end
         end
         if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
               3'd0: t_to <= 1'b0;
               3'd1: begin
                  t_ito  <= tmr_writedata[0];
                  t_cont <= tmr_writedata[1];
                  if (tmr_writedata[2]) t_run <= 1'b1;
                  if (tmr_writedata[3]) t_run <= 1'b0;
               end
               3'd2: begin t_pl <= tmr_writedata; t_cnt <= {t_ph, tmr_writedata}; t_run <= 1'b0; end
               3'd3: begin t_ph <= tmr_writedata; t_cnt <= {tmr_writedata, t_pl}; t_run <= 1'b0; end
               default: ;
            endcase
         end
      end
   end

   assign tmr_irq = t_to & t_ito;

   // Bus write log, strobe sanity and grant/done event log
   always @(posedge clk) begin
      if (tmr_chipselect && !tmr_write_n) wr_q.push_back({tmr_address, tmr_writedata});
      if (tmr_chipselect == tmr_write_n) bad_strobe <= bad_strobe + 1;
      for (int i = 0; i < NR; i++) begin
         if (req_ready[i] && req_valid[i]) ev_q.push_back(10 + i);
         if (done[i]) ev_q.push_back(20 + i);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_wr(input string name, input int idx, input logic [2:0] a, input logic [15:0] d);
      if (idx < wr_q.size()) check(name, 32'(wr_q[idx]), 32'({a, d}));
      else check(name, 32'hFFFF_FFFF, 32'({a, d}));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_done_aborted"}, 32'(done_aborted), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_active_id"}, 32'(active_id), 0);
      check({tag, "_cs"}, 32'(tmr_chipselect), 0);
      check({tag, "_write_n"}, 32'(tmr_write_n), 1);
      check({tag, "_address"}, 32'(tmr_address), 0);
      check({tag, "_writedata"}, 32'(tmr_writedata), 0);
   endtask

   task automatic start_request(input int id, input logic [31:0] p);
      bit got;
      got = 1'b0;
      wr_q.delete();
      @(negedge clk);
      req_period[id*PW +: PW] = p;
      req_valid[id] = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1'b1;
      end
      check("accept", 32'(got), 1);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
      check("busy_after_accept", 32'(busy), 1);
      check("active_id", 32'(active_id), 32'(id));
   endtask

   task automatic wait_done(input int limit, output int lat, output logic ab, output logic [NR-1:0] dn);
      bit got;
      got = 1'b0; lat = -1; ab = 1'b0; dn = '0;
      for (int k = 0; k < limit && !got; k++) begin
         @(negedge clk);
         if (|done) begin
            got = 1'b1;
            lat = cyc - acc_cyc;
            ab  = done_aborted;
            dn  = done;
         end
      end
      check("done_seen", 32'(got), 1);
      $display("[TB] done=0x%0h aborted=%0d latency=%0d writes=%0d", dn, ab, lat, wr_q.size());
      @(negedge clk);
      check("idle_after_done", 32'(busy), 0);
   endtask

   task automatic run_normal(input int id, input logic [31:0] p, input logic [15:0] pl, input logic [15:0] ph);
      int lat;
      logic ab;
      logic [NR-1:0] dn;
      start_request(id, p);
      wait_done(int'(p) + 40, lat, ab, dn);
      check("done_id", 32'(dn), 32'(1) << id);
      check("done_aborted", 32'(ab), 0);
      if (p == 0) begin
         check("p0_latency", 32'(lat), 1);
         check("p0_no_writes", 32'(wr_q.size()), 0);
      end else begin
         check("latency_in_range", 32'((lat >= int'(p)) && (lat <= int'(p) + 8)), 1);
         check("num_writes", 32'(wr_q.size()), 4);
         check_wr("wr_periodl", 0, 3'd2, pl);
         check_wr("wr_periodh", 1, 3'd3, ph);
         check_wr("wr_control", 2, 3'd1, 16'h0005);
         check_wr("wr_status", 3, 3'd0, 16'h0000);
      end
   endtask

   typedef struct {
      int          id;
      logic [31:0] period;
      logic [15:0] exp_pl;
      logic [15:0] exp_ph;
   } vec_t;

   vec_t vecs[5];
   int   exp_ev[10];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic ab;
      logic [NR-1:0] dn;
      bit got;
      bit rereq;
      int g;
      int n_done;

      vecs[0] = '{0, 32'd100,        16'h0063, 16'h0000};
      vecs[1] = '{1, 32'd1,          16'h0000, 16'h0000};
      vecs[2] = '{3, 32'd17,         16'h0010, 16'h0000};
      vecs[3] = '{2, 32'd0,          16'h0000, 16'h0000};
      vecs[4] = '{1, 32'd256,        16'h00FF, 16'h0000};
      exp_ev  = '{10, 20, 11, 21, 12, 22, 13, 23, 10, 20};

      reset_n = 1'b0; req_valid = '0; req_period = '0; abort = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Round robin: all four valid with P=10, requester 0 re-requests after its done
      ev_q.delete();
      req_period = {NR{32'd10}};
      req_valid  = 4'hF;
      rereq = 1'b0;
      for (int k = 0; k < 400 && ev_q.size() < 10; k++) begin
         @(negedge clk);
         if (|req_ready) begin
            g = 0;
            for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
            $display("[TB] rr grant %0d at cycle %0d", g, cyc);
            @(posedge clk);
            #1;
            req_valid[g] = 1'b0;
         end else if (done[0] && !rereq) begin
            req_valid[0] = 1'b1;
            rereq = 1'b1;
         end
      end
      for (int i = 0; i < 10; i++) begin
         if (i < ev_q.size()) check("rr_event", 32'(ev_q[i]), 32'(exp_ev[i]));
         else check("rr_event", 32'hFFFF_FFFF, 32'(exp_ev[i]));
      end
      repeat (3) @(negedge clk);

      // Table of single normal requests
      for (int v = 0; v < 5; v++) begin
         run_normal(vecs[v].id, vecs[v].period, vecs[v].exp_pl, vecs[v].exp_ph);
      end

      // Wide period on requester 2, cut short by abort to keep the run brief
      start_request(2, 32'h0001_2345);
      repeat (30) @(negedge clk);
      check("wide_active_id", 32'(active_id), 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(40, lat, ab, dn);
      check("wide_done_id", 32'(dn), 32'h4);
      check_wr("wide_periodl", 0, 3'd2, 16'h2344);
      check_wr("wide_periodh", 1, 3'd3, 16'h0001);
      n_done = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (|done) n_done++;
      end
      check("wide_single_done", 32'(n_done), 0);

      // Abort ~20 cycles into a P=1000 wait
      start_request(0, 32'd1000);
      repeat (23) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(60, lat, ab, dn);
      check("abort_done_id", 32'(dn), 32'h1);
      check("abort_flag", 32'(ab), 1);
      check("abort_num_writes", 32'(wr_q.size()), 5);
      check_wr("abort_stop_wr", 3, 3'd1, 16'h0008);
      check_wr("abort_clr_wr", 4, 3'd0, 16'h0000);
      run_normal(2, 32'd5, 16'h0004, 16'h0000);

      // Abort during the register writes is held until WAIT
      start_request(1, 32'd50);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      wait_done(90, lat, ab, dn);
      check("pend_abort_flag", 32'(ab), 1);
      check_wr("pend_stop_wr", 3, 3'd1, 16'h0008);

      // Abort in the same cycle irq is seen: irq wins
      start_request(3, 32'd6);
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (tmr_irq) got = 1'b1;
      end
      check("irq_seen", 32'(got), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(20, lat, ab, dn);
      check("irq_wins_done_id", 32'(dn), 32'h8);
      check("irq_wins_flag", 32'(ab), 0);
      check("irq_wins_num_writes", 32'(wr_q.size()), 4);
      check_wr("irq_wins_clr_wr", 3, 3'd0, 16'h0000);

      // Reset pulsed during WAIT, then a normal request
      start_request(3, 32'd1000);
      repeat (30) @(negedge clk);
      check("busy_in_wait", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_normal(1, 32'd12, 16'h000B, 16'h0000);

      check("bus_strobe_pairing", 32'(bad_strobe), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
